// File: rtl/hash_table_pkg.sv
// Shared types for the hash_table command front-end: op codes issued to
// hash_table and the state encoding of the command queue sequencer.
package hash_table_pkg;

   // Operation codes understood by hash_table; 2'b11 is never issued to it
   typedef enum logic [1:0] {
      HT_INSERT  = 2'b00,
      HT_DELETE  = 2'b01,
      HT_SEARCH  = 2'b10,
      HT_ILLEGAL = 2'b11
   } ht_op_e;

   // Sequencer states: waiting for work, op in flight, response held
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } cmdq_state_e;

   // Width of an occupancy counter that must represent 0..depth inclusive
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/hash_table_cmd_queue_cmd_fifo.sv
// Synchronous FIFO holding packed {op, key, value} commands. The head entry
// is always visible on pop_data; pop only advances the read pointer.
module cmd_fifo
   import hash_table_pkg::*;
#(
   parameter int WIDTH = 66,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [WIDTH-1:0]              push_data,
   input  logic                          pop,
   output logic [WIDTH-1:0]              pop_data,
   output logic [count_width(DEPTH)-1:0] count,
   output logic                          full,
   output logic                          empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = count_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage array; contents are don't-care until written so no reset is needed
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; a simultaneous
   // push and pop leaves the occupancy unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/hash_table_cmd_queue.sv
// Command front-end for hash_table: buffers insert/delete/search requests,
// issues them one at a time on the op_en/op_done handshake, aborts ops that
// hang past a cycle budget, and returns each result on a valid/ready port.
module hash_table_cmd_queue
   import hash_table_pkg::*;
#(
   parameter int KEY_WIDTH      = 32,
   parameter int VALUE_WIDTH    = 32,
   parameter int CHAINING_SIZE  = 4,
   parameter int CMD_DEPTH      = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  cmd_valid,
   output logic                                  cmd_ready,
   input  logic [1:0]                            cmd_op,
   input  logic [KEY_WIDTH-1:0]                  cmd_key,
   input  logic [VALUE_WIDTH-1:0]                cmd_value,
   output logic                                  rsp_valid,
   input  logic                                  rsp_ready,
   output logic [1:0]                            rsp_op,
   output logic [KEY_WIDTH-1:0]                  rsp_key,
   output logic [VALUE_WIDTH-1:0]                rsp_value,
   output logic                                  rsp_error,
   output logic                                  rsp_timeout,
   output logic [$clog2(CHAINING_SIZE)-1:0]      rsp_collision_count,
   output logic [$clog2(CMD_DEPTH):0]            cmd_count,
   output logic [KEY_WIDTH-1:0]                  ht_key_in,
   output logic [VALUE_WIDTH-1:0]                ht_value_in,
   output logic [1:0]                            ht_op_sel,
   output logic                                  ht_op_en,
   input  logic [VALUE_WIDTH-1:0]                ht_value_out,
   input  logic                                  ht_op_done,
   input  logic                                  ht_op_error,
   input  logic [$clog2(CHAINING_SIZE)-1:0]      ht_collision_count
);

   localparam int CHAIN_WIDTH = $clog2(CHAINING_SIZE);
   localparam int DATA_W      = 2 + KEY_WIDTH + VALUE_WIDTH;
   localparam int TMR_W       = $clog2(TIMEOUT_CYCLES) + 1;

   cmdq_state_e            state;
   logic [TMR_W-1:0]       timer;
   logic [DATA_W-1:0]      push_word;
   logic [DATA_W-1:0]      head_word;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   push;
   logic                   pop;
   ht_op_e                 head_op;
   logic [KEY_WIDTH-1:0]   head_key;
   logic [VALUE_WIDTH-1:0] head_value;

   // cmd_ready comes straight from the registered occupancy, so a full
   // FIFO never accepts a write even when a pop happens in the same cycle
   assign cmd_ready  = !fifo_full;
   assign push       = cmd_valid && cmd_ready;
   assign push_word  = {cmd_op, cmd_key, cmd_value};

   assign head_op    = ht_op_e'(head_word[DATA_W-1 -: 2]);
   assign head_key   = head_word[KEY_WIDTH+VALUE_WIDTH-1 -: KEY_WIDTH];
   assign head_value = head_word[VALUE_WIDTH-1:0];

   // Only start a new command once the previous response has drained and
   // hash_table has released op_done, keeping exactly one op outstanding
   assign pop = (state == IDLE) && !fifo_empty && !rsp_valid && !ht_op_done;

   cmd_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_word),
      .pop       (pop),
      .pop_data  (head_word),
      .count     (cmd_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Sequencer: IDLE pops and latches the operands, BUSY raises op_en one
   // edge later and waits for op_done or the timeout, RESP holds the result
   // until the consumer takes it. op_en is low in IDLE and RESP, which
   // guarantees at least one low cycle between consecutive ops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state               <= IDLE;
         timer               <= '0;
         ht_op_en            <= 1'b0;
         ht_key_in           <= '0;
         ht_value_in         <= '0;
         ht_op_sel           <= 2'b00;
         rsp_valid           <= 1'b0;
         rsp_op              <= 2'b00;
         rsp_key             <= '0;
         rsp_value           <= '0;
         rsp_error           <= 1'b0;
         rsp_timeout         <= 1'b0;
         rsp_collision_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  if (head_op == HT_ILLEGAL) begin
                     rsp_op              <= head_op;
                     rsp_key             <= head_key;
                     rsp_value           <= '0;
                     rsp_error           <= 1'b1;
                     rsp_timeout         <= 1'b0;
                     rsp_collision_count <= '0;
                     rsp_valid           <= 1'b1;
                     state               <= RESP;
                  end else begin
                     ht_key_in   <= head_key;
                     ht_value_in <= head_value;
                     ht_op_sel   <= head_op;
                     timer       <= '0;
                     state       <= BUSY;
                  end
               end
            end

            BUSY: begin
               if (!ht_op_en) begin
                  ht_op_en <= 1'b1;
                  timer    <= '0;
               end else if (ht_op_done) begin
                  ht_op_en            <= 1'b0;
                  rsp_op              <= ht_op_sel;
                  rsp_key             <= ht_key_in;
                  rsp_value           <= ht_value_out;
                  rsp_error           <= ht_op_error;
                  rsp_timeout         <= 1'b0;
                  rsp_collision_count <= ht_collision_count;
                  rsp_valid           <= 1'b1;
                  state               <= RESP;
               end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                  ht_op_en            <= 1'b0;
                  rsp_op              <= ht_op_sel;
                  rsp_key             <= ht_key_in;
                  rsp_value           <= '0;
                  rsp_error           <= 1'b1;
                  rsp_timeout         <= 1'b1;
                  rsp_collision_count <= CHAIN_WIDTH'(0);
                  rsp_valid           <= 1'b1;
                  state               <= RESP;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               ht_op_en  <= 1'b0;
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hash_table_cmd_queue.sv
// Self-checking bench for hash_table_cmd_queue. A behavioural hash_table
// (modulus hash over 8 buckets, 4-deep chains, fixed latency) answers the
// DUT; a stub switch holds op_done low to exercise the timeout path.
module tb_hash_table_cmd_queue;

   localparam int KW  = 32;
   localparam int VW  = 32;
   localparam int CS  = 4;
   localparam int CD  = 4;
   localparam int TO  = 64;
   localparam int CW  = $clog2(CS);
   localparam int NBK = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [KW-1:0] cmd_key;
   logic [VW-1:0] cmd_value;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [1:0]    rsp_op;
   logic [KW-1:0] rsp_key;
   logic [VW-1:0] rsp_value;
   logic          rsp_error;
   logic          rsp_timeout;
   logic [CW-1:0] rsp_collision_count;
   logic [$clog2(CD):0] cmd_count;
   logic [KW-1:0] ht_key_in;
   logic [VW-1:0] ht_value_in;
   logic [1:0]    ht_op_sel;
   logic          ht_op_en;
   logic [VW-1:0] ht_value_out;
   logic          ht_op_done;
   logic          ht_op_error;
   logic [CW-1:0] ht_collision_count;

   int checks = 0;
   int errors = 0;
   logic stub = 1'b0;

   always #5 clk = ~clk;

   hash_table_cmd_queue #(
      .KEY_WIDTH      (KW),
      .VALUE_WIDTH    (VW),
      .CHAINING_SIZE  (CS),
      .CMD_DEPTH      (CD),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .cmd_valid           (cmd_valid),
      .cmd_ready           (cmd_ready),
      .cmd_op              (cmd_op),
      .cmd_key             (cmd_key),
      .cmd_value           (cmd_value),
      .rsp_valid           (rsp_valid),
      .rsp_ready           (rsp_ready),
      .rsp_op              (rsp_op),
      .rsp_key             (rsp_key),
      .rsp_value           (rsp_value),
      .rsp_error           (rsp_error),
      .rsp_timeout         (rsp_timeout),
      .rsp_collision_count (rsp_collision_count),
      .cmd_count           (cmd_count),
      .ht_key_in           (ht_key_in),
      .ht_value_in         (ht_value_in),
      .ht_op_sel           (ht_op_sel),
      .ht_op_en            (ht_op_en),
      .ht_value_out        (ht_value_out),
      .ht_op_done          (ht_op_done),
      .ht_op_error         (ht_op_error),
      .ht_collision_count  (ht_collision_count)
   );

   // Behavioural hash_table storage
   logic [KW-1:0] tbl_key [NBK][CS];
   logic [VW-1:0] tbl_val [NBK][CS];
   logic          tbl_vld [NBK][CS];
   int            lat;

   function automatic logic hasKey(input logic [KW-1:0] k);
      logic r = 1'b0;
      for (int s = 0; s < CS; s++)
         if (tbl_vld[k[2:0]][s] && tbl_key[k[2:0]][s] == k) r = 1'b1;
      return r;
   endfunction

   function automatic logic [1:0] keySlot(input logic [KW-1:0] k);
      logic [1:0] r = 2'd0;
      for (int s = CS - 1; s >= 0; s--)
         if (tbl_vld[k[2:0]][s] && tbl_key[k[2:0]][s] == k) r = 2'(s);
      return r;
   endfunction

   function automatic logic hasFree(input logic [2:0] b);
      logic r = 1'b0;
      for (int s = 0; s < CS; s++)
         if (!tbl_vld[b][s]) r = 1'b1;
      return r;
   endfunction

   function automatic logic [1:0] freeSlot(input logic [2:0] b);
      logic [1:0] r = 2'd0;
      for (int s = CS - 1; s >= 0; s--)
         if (!tbl_vld[b][s]) r = 2'(s);
      return r;
   endfunction

   function automatic logic [CW-1:0] collCount(input logic [2:0] b);
      int n = 0;
      for (int s = 0; s < CS; s++)
         if (tbl_vld[b][s]) n++;
      return (n > 3) ? CW'(3) : CW'(n);
   endfunction

   // hash_table model: answers three edges after op_en rises with a
   // one-cycle op_done pulse; stub mode never answers
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < NBK; b++)
            for (int s = 0; s < CS; s++) begin
               tbl_vld[b][s] <= 1'b0;
               tbl_key[b][s] <= '0;
               tbl_val[b][s] <= '0;
            end
         lat                <= 0;
         ht_op_done         <= 1'b0;
         ht_op_error        <= 1'b0;
         ht_value_out       <= '0;
         ht_collision_count <= '0;
      end else begin
         ht_op_done <= 1'b0;
         if (ht_op_en && !ht_op_done && !stub) begin
            if (lat == 2) begin
               lat                <= 0;
               ht_op_done         <= 1'b1;
               ht_collision_count <= collCount(ht_key_in[2:0]);
               ht_value_out       <= '0;
               ht_op_error        <= 1'b0;
               case (ht_op_sel)
                  2'b00: begin
                     if (hasKey(ht_key_in)) begin
                        tbl_val[ht_key_in[2:0]][keySlot(ht_key_in)] <= ht_value_in;
                     end else if (hasFree(ht_key_in[2:0])) begin
                        tbl_vld[ht_key_in[2:0]][freeSlot(ht_key_in[2:0])] <= 1'b1;
                        tbl_key[ht_key_in[2:0]][freeSlot(ht_key_in[2:0])] <= ht_key_in;
                        tbl_val[ht_key_in[2:0]][freeSlot(ht_key_in[2:0])] <= ht_value_in;
                     end else begin
                        ht_op_error <= 1'b1;
                     end
                  end
                  2'b01: begin
                     if (hasKey(ht_key_in))
                        tbl_vld[ht_key_in[2:0]][keySlot(ht_key_in)] <= 1'b0;
                     else
                        ht_op_error <= 1'b1;
                  end
                  2'b10: begin
                     if (hasKey(ht_key_in))
                        ht_value_out <= tbl_val[ht_key_in[2:0]][keySlot(ht_key_in)];
                     else
                        ht_op_error <= 1'b1;
                  end
                  default: ht_op_error <= 1'b1;
               endcase
            end else begin
               lat <= lat + 1;
            end
         end else if (!ht_op_en) begin
            lat <= 0;
         end
      end
   end

   // Activity monitors on ht_op_en: rising edges and cycles spent high
   logic op_en_prev = 1'b0;
   int   en_rises   = 0;
   int   en_hi      = 0;
   always @(posedge clk) begin
      op_en_prev <= ht_op_en;
      if (ht_op_en && !op_en_prev) en_rises <= en_rises + 1;
      if (ht_op_en) en_hi <= en_hi + 1;
   end

   typedef struct {
      logic [1:0]    op;
      logic [KW-1:0] key;
      logic [VW-1:0] value;
      logic [VW-1:0] exp_value;
      logic          exp_error;
      logic          exp_timeout;
      logic [CW-1:0] exp_coll;
   } vec_t;

   vec_t vecs [13];

   task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Offer one command starting from a negedge; returns at the negedge after acceptance
   task automatic applyStimulus(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val);
      int w = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_key   = key;
      cmd_value = val;
      while (!cmd_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!cmd_ready) checkValue("cmd_accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Wait for a response (rsp_ready held high) and compare every field
   task automatic checkOutput(input string tag, input logic [1:0] op, input logic [KW-1:0] key,
                              input logic [VW-1:0] val, input logic err, input logic tmo,
                              input logic [CW-1:0] coll);
      int w = 0;
      while (!rsp_valid && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (!rsp_valid) begin
         checkValue({tag, "_rsp_wait"}, 64'd0, 64'd1);
      end else begin
         checkValue({tag, "_op"}, 64'(rsp_op), 64'(op));
         checkValue({tag, "_key"}, 64'(rsp_key), 64'(key));
         checkValue({tag, "_value"}, 64'(rsp_value), 64'(val));
         checkValue({tag, "_error"}, 64'(rsp_error), 64'(err));
         checkValue({tag, "_timeout"}, 64'(rsp_timeout), 64'(tmo));
         checkValue({tag, "_coll"}, 64'(rsp_collision_count), 64'(coll));
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      int r0;
      int h0;
      int w;

      // Bucket 3 chain fill, overflow, search/delete/reinsert, miss, illegal, hit
      vecs[0]  = '{2'b00, 32'd3,  32'd30,  32'd0,   1'b0, 1'b0, 2'd0};
      vecs[1]  = '{2'b00, 32'd11, 32'd110, 32'd0,   1'b0, 1'b0, 2'd1};
      vecs[2]  = '{2'b00, 32'd19, 32'd190, 32'd0,   1'b0, 1'b0, 2'd2};
      vecs[3]  = '{2'b00, 32'd27, 32'd270, 32'd0,   1'b0, 1'b0, 2'd3};
      vecs[4]  = '{2'b00, 32'd35, 32'd350, 32'd0,   1'b1, 1'b0, 2'd3};
      vecs[5]  = '{2'b10, 32'd19, 32'd0,   32'd190, 1'b0, 1'b0, 2'd3};
      vecs[6]  = '{2'b10, 32'd35, 32'd0,   32'd0,   1'b1, 1'b0, 2'd3};
      vecs[7]  = '{2'b01, 32'd11, 32'd0,   32'd0,   1'b0, 1'b0, 2'd3};
      vecs[8]  = '{2'b00, 32'd35, 32'd350, 32'd0,   1'b0, 1'b0, 2'd3};
      vecs[9]  = '{2'b10, 32'd35, 32'd0,   32'd350, 1'b0, 1'b0, 2'd3};
      vecs[10] = '{2'b01, 32'd42, 32'd0,   32'd0,   1'b1, 1'b0, 2'd0};
      vecs[11] = '{2'b11, 32'd5,  32'd77,  32'd0,   1'b1, 1'b0, 2'd0};
      vecs[12] = '{2'b10, 32'd1,  32'd0,   32'd2,   1'b0, 1'b0, 2'd1};

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_key   = '0;
      cmd_value = '0;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      checkValue("reset_cmd_ready", 64'(cmd_ready), 64'd1);
      checkValue("reset_cmd_count", 64'(cmd_count), 64'd0);
      checkValue("reset_op_en", 64'(ht_op_en), 64'd0);
      checkValue("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] delete on empty table with issue/response latency");
      applyStimulus(2'b01, 32'd1, 32'd0);
      checkValue("lat_op_en_n0", 64'(ht_op_en), 64'd0);
      @(negedge clk);
      checkValue("lat_op_en_n1", 64'(ht_op_en), 64'd0);
      @(negedge clk);
      checkValue("lat_op_en_n2", 64'(ht_op_en), 64'd1);
      w = 0;
      while (!ht_op_done && w < 50) begin
         @(negedge clk);
         w++;
      end
      checkValue("lat_done_seen", 64'(ht_op_done), 64'd1);
      checkValue("lat_rsp_before", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      checkValue("lat_rsp_after", 64'(rsp_valid), 64'd1);
      checkOutput("del_empty", 2'b01, 32'd1, 32'd0, 1'b1, 1'b0, 2'd0);

      $display("[TB] back-to-back insert then search");
      applyStimulus(2'b00, 32'd1, 32'd2);
      applyStimulus(2'b10, 32'd1, 32'd0);
      checkOutput("b2b_ins", 2'b00, 32'd1, 32'd0, 1'b0, 1'b0, 2'd0);
      checkOutput("b2b_srch", 2'b10, 32'd1, 32'd2, 1'b0, 1'b0, 2'd1);

      $display("[TB] response backpressure fills the queue");
      rsp_ready = 1'b0;
      applyStimulus(2'b10, 32'd1, 32'd0);
      applyStimulus(2'b10, 32'd9, 32'd0);
      applyStimulus(2'b10, 32'd1, 32'd0);
      applyStimulus(2'b10, 32'd17, 32'd0);
      applyStimulus(2'b10, 32'd25, 32'd0);
      repeat (20) @(negedge clk);
      checkValue("bp_cmd_count", 64'(cmd_count), 64'd4);
      checkValue("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      checkValue("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      checkValue("bp_op_en_idle", 64'(ht_op_en), 64'd0);
      rsp_ready = 1'b1;
      checkOutput("bp0", 2'b10, 32'd1,  32'd2, 1'b0, 1'b0, 2'd1);
      checkOutput("bp1", 2'b10, 32'd9,  32'd0, 1'b1, 1'b0, 2'd1);
      checkOutput("bp2", 2'b10, 32'd1,  32'd2, 1'b0, 1'b0, 2'd1);
      checkOutput("bp3", 2'b10, 32'd17, 32'd0, 1'b1, 1'b0, 2'd1);
      checkOutput("bp4", 2'b10, 32'd25, 32'd0, 1'b1, 1'b0, 2'd1);

      $display("[TB] table-driven vectors");
      for (int i = 0; i < 13; i++) begin
         r0 = en_rises;
         applyStimulus(vecs[i].op, vecs[i].key, vecs[i].value);
         checkOutput($sformatf("vec%0d", i), vecs[i].op, vecs[i].key, vecs[i].exp_value,
                     vecs[i].exp_error, vecs[i].exp_timeout, vecs[i].exp_coll);
         if (vecs[i].op == 2'b11)
            checkValue($sformatf("vec%0d_no_op_en", i), 64'(en_rises - r0), 64'd0);
      end

      $display("[TB] hung hash_table op times out");
      stub = 1'b1;
      h0 = en_hi;
      applyStimulus(2'b10, 32'd1, 32'd0);
      checkOutput("tmo", 2'b10, 32'd1, 32'd0, 1'b1, 1'b1, 2'd0);
      checkValue("tmo_op_en_cycles", 64'(en_hi - h0), 64'(TO));
      stub = 1'b0;
      applyStimulus(2'b10, 32'd1, 32'd0);
      checkOutput("after_tmo", 2'b10, 32'd1, 32'd2, 1'b0, 1'b0, 2'd1);

      $display("[TB] reset while busy with queued commands");
      stub = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(2'b10, 32'd1, 32'd0);
      w = 0;
      while (!ht_op_en && w < 20) begin
         @(negedge clk);
         w++;
      end
      checkValue("rst_busy_op_en", 64'(ht_op_en), 64'd1);
      checkValue("rst_busy_count", 64'(cmd_count), 64'd3);
      rst = 1'b1;
      #1;
      checkValue("rst_async_op_en", 64'(ht_op_en), 64'd0);
      checkValue("rst_async_rsp_valid", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      rst  = 1'b0;
      stub = 1'b0;
      @(negedge clk);
      checkValue("rst_after_count", 64'(cmd_count), 64'd0);
      checkValue("rst_after_ready", 64'(cmd_ready), 64'd1);
      repeat (3) @(negedge clk);
      checkValue("rst_after_op_en", 64'(ht_op_en), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
